reed_solomon_decoder_wr_scheduler: RTL
======================================

Name: reed_solomon_decoder_wr_scheduler

Overview:
Sequences all CCI-P channel-1 traffic for the Reed-Solomon decoder AFU. Packs the decoder's byte output into 64-byte cache lines and holds them in an N-entry ping-pong line buffer. Issues line writes to the output buffer under c1TxAlmFull backpressure, then issues the DSM completion write once every data write has been acknowledged. Exerts ready/valid backpressure on the decoder so that a full line is never overwritten while the channel is stalled.

Parameters:
NUM_BUFS, 2, number of 64-byte line slots; power of two, ≥2.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
hc_control  in  32  host control word; HC_CONTROL_START begins operation
hc_dsm_base  in  t_hc_address  DSM line address for the completion write
wr_base  in  t_ccip_clAddr  output buffer base line address
wr_size  in  t_ccip_clAddr  output length in lines; must be ≥1
data_in  in  8  decoded byte
valid_in  in  1  data_in valid
ready_out  out  1  scheduler accepts a byte this cycle
ccip_rx  in  t_if_ccip_Rx  uses c1TxAlmFull, c1.rspValid, c1.hdr.resp_type
ccip_c1_tx  out  t_if_ccip_c1_Tx  write request channel
done  out  1  completion write issued; sticky until reset
overflow_err  out  1  sticky; valid_in seen while ready_out=0

Behaviour:
- Reset (async): state IDLE; all pointers and counters 0; ccip_c1_tx.valid=0, hdr=0, data=0; ready_out=0; done=0; overflow_err=0.
- Byte accepted when valid_in && ready_out.
- Packing: byte k of a line (k=0..63, arrival order) lands in data bits [511-8k -: 8]. The first byte occupies the MSB lane.
- After byte 63 is accepted, the fill slot is sealed. fill_ptr advances mod NUM_BUFS and sealed_cnt increments.
- lines_sealed counts lines sealed. ready_out = (state==RUN) && (sealed_cnt < NUM_BUFS) && (lines_sealed < wr_size); registered, no combinational path from ccip_rx.
- Issue rule: in RUN or DRAIN, when sealed_cnt>0 && !c1TxAlmFull, drive the following next cycle:
  - valid=1
  - hdr.address = wr_base + wr_offset
  - hdr.sop=1, hdr.cl_len=eCL_LEN_1, hdr.req_type=eREQ_WRLINE_I
  - data = slot[issue_ptr]
  Then issue_ptr++, wr_offset++, sealed_cnt--. Otherwise valid=0 (a one-cycle pulse per request).
- Simultaneous seal and issue: sealed_cnt unchanged; both pointers advance. A slot being issued is never the fill target, because ready_out guards sealed_cnt==NUM_BUFS.
- wr_rsp_cnt increments on c1.rspValid && resp_type==eRSP_WRLINE. All counters are t_ccip_clAddr width and wrap silently (never reached in legal use).
- States:
  - IDLE → RUN when hc_control==HC_CONTROL_START.
  - RUN → DRAIN when lines_sealed==wr_size.
  - DRAIN → DSM when wr_offset==wr_size && wr_rsp_cnt==wr_size.
  - DSM: when !c1TxAlmFull, issue one write: address=hc_dsm_base, data=512'h1, sop=1. Then → DONE.
  - DONE: valid=0, done=1; hold until reset.
- hc_control deasserting after START has no effect.
- overflow_err sets on valid_in && !ready_out in RUN. The byte is dropped and no slot is modified.
- Bytes beyond wr_size*64 are never accepted. Partial trailing lines are not flushed.
- Reset mid-operation: immediate return to IDLE; in-flight responses arriving after reset are ignored (counter cleared).

Decomposition:
- reed_solomon_decoder_pkg gains:
  - t_wrs_state enum {S_WRS_IDLE, S_WRS_RUN, S_WRS_DRAIN, S_WRS_DSM, S_WRS_DONE}
  - localparam CL_BYTES=64
- Sub-module reed_solomon_decoder_line_buffer: NUM_BUFS×512-bit storage. Holds byte_ptr, fill_ptr, issue_ptr and sealed_cnt; exposes seal/pop/full/empty/rd_data.
- The top level holds the FSM, address and response counters, and CCI-P drive.

Test Plan:
- wr_size=2, continuous valid_in, AlmFull=0, immediate responses → exactly 2 writes:
  - addresses wr_base+0 and wr_base+1
  - line 0 bits[511:504]=first byte (0x00 for ramp 0..127)
  - then one DSM write of data 1
  - done=1
- wr_size=4, AlmFull held high for 300 cycles → ready_out drops after 128 bytes, no write issued, overflow_err=0. On release, 4 writes in order with intact data.
- Force valid_in=1 while ready_out=0 → overflow_err=1 sticky; that byte does not appear in any written line.
- Seal on the same cycle as an issue (AlmFull toggled 1 cycle before byte 63) → sealed_cnt stays constant and line order is preserved.
- Withhold write responses after the last data write → DSM write not issued until wr_rsp_cnt==wr_size, then issued within 2 cycles.
- Assert reset in the middle of line 1 → all outputs return to reset values next clock. A new START with wr_size=1 produces a clean single write plus DSM.

Source files
------------

// File: rtl/reed_solomon_decoder_pkg.sv
// Shared types for the Reed-Solomon decoder AFU: the CCI-P subset used on
// channel 1, write-scheduler states and cache-line geometry.
package reed_solomon_decoder_pkg;

   localparam int CL_BYTES = 64;
   localparam int CL_BITS  = CL_BYTES * 8;

   localparam logic [31:0] HC_CONTROL_START = 32'h0000_0001;

   typedef logic [41:0] t_ccip_clAddr;
   typedef t_ccip_clAddr t_hc_address;
   typedef logic [15:0] t_ccip_mdata;

   typedef enum logic [1:0] {
      eVC_VA  = 2'b00,
      eVC_VL0 = 2'b01,
      eVC_VH0 = 2'b10,
      eVC_VH1 = 2'b11
   } t_ccip_vc;

   typedef enum logic [1:0] {
      eCL_LEN_1 = 2'b00,
      eCL_LEN_2 = 2'b01,
      eCL_LEN_4 = 2'b11
   } t_ccip_clLen;

   typedef enum logic [3:0] {
      eREQ_WRLINE_I = 4'h0,
      eREQ_WRLINE_M = 4'h1,
      eREQ_WRFENCE  = 4'h4
   } t_ccip_c1_req;

   typedef enum logic [3:0] {
      eRSP_WRLINE  = 4'h0,
      eRSP_WRFENCE = 4'h4
   } t_ccip_c1_rsp;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic         sop;
      t_ccip_clLen  cl_len;
      t_ccip_c1_req req_type;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_vc     vc_used;
      logic         hit_miss;
      logic         format;
      logic [1:0]   cl_num;
      t_ccip_c1_rsp resp_type;
      t_ccip_mdata  mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;

   // Only the channel-1 side of the receive bundle is modelled in this slice.
   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef enum logic [2:0] {
      S_WRS_IDLE,
      S_WRS_RUN,
      S_WRS_DRAIN,
      S_WRS_DSM,
      S_WRS_DONE
   } t_wrs_state;

   function automatic t_ccip_c1_ReqMemHdr wrline_hdr(input t_ccip_clAddr addr);
      t_ccip_c1_ReqMemHdr h;
      h          = '0;
      h.sop      = 1'b1;
      h.cl_len   = eCL_LEN_1;
      h.req_type = eREQ_WRLINE_I;
      h.address  = addr;
      return h;
   endfunction

endpackage

// File: rtl/reed_solomon_decoder_wr_scheduler_if.sv
// Byte stream from the decoder plus the CCI-P channel-1 bundle seen by the
// write scheduler; slave is the scheduler side.
interface reed_solomon_decoder_wr_scheduler_if;
   import reed_solomon_decoder_pkg::*;

   logic [7:0]     data_in;
   logic           valid_in;
   logic           ready_out;
   t_if_ccip_Rx    ccip_rx;
   t_if_ccip_c1_Tx ccip_c1_tx;

   modport master (
      output data_in, valid_in, ccip_rx,
      input  ready_out, ccip_c1_tx
   );

   modport slave (
      input  data_in, valid_in, ccip_rx,
      output ready_out, ccip_c1_tx
   );

endinterface

// File: rtl/reed_solomon_decoder_line_buffer.sv
// NUM_BUFS-slot ring of 64-byte lines: bytes fill one slot MSB-lane first,
// a full slot is sealed and later popped in order by the issue side.
module reed_solomon_decoder_line_buffer
   import reed_solomon_decoder_pkg::*;
#(
   parameter int NUM_BUFS = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [7:0]         wr_byte,
   input  logic               pop,
   output logic               seal,
   output logic               full_next,
   output logic               empty,
   output logic [CL_BITS-1:0] rd_data
);

   localparam int PTR_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
   localparam int CNT_W = $clog2(NUM_BUFS) + 1;

   logic [CL_BITS-1:0] line_mem [NUM_BUFS];
   logic [5:0]         byte_ptr_reg;
   logic [PTR_W-1:0]   fill_ptr_reg;
   logic [PTR_W-1:0]   issue_ptr_reg;
   logic [CNT_W-1:0]   sealed_cnt_reg;
   logic [CNT_W-1:0]   sealed_cnt_next;
   logic [8:0]         lane_msb;

   assign seal     = wr_en && (byte_ptr_reg == 6'(CL_BYTES - 1));
   assign lane_msb = 9'd511 - {byte_ptr_reg, 3'b000};

   always_comb begin
      sealed_cnt_next = sealed_cnt_reg;
      if (seal && !pop) begin
         sealed_cnt_next = sealed_cnt_reg + CNT_W'(1);
      end else if (pop && !seal) begin
         sealed_cnt_next = sealed_cnt_reg - CNT_W'(1);
      end
   end

   assign full_next = (sealed_cnt_next == CNT_W'(NUM_BUFS));
   assign empty     = (sealed_cnt_reg == '0);
   assign rd_data   = line_mem[issue_ptr_reg];

   // Storage carries no reset so it maps onto RAM; pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_mem[fill_ptr_reg][lane_msb -: 8] <= wr_byte;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_ptr_reg   <= '0;
         fill_ptr_reg   <= '0;
         issue_ptr_reg  <= '0;
         sealed_cnt_reg <= '0;
      end else begin
         sealed_cnt_reg <= sealed_cnt_next;
         if (wr_en) begin
            byte_ptr_reg <= byte_ptr_reg + 6'd1;
         end
         if (seal) begin
            fill_ptr_reg <= fill_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            issue_ptr_reg <= issue_ptr_reg + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/reed_solomon_decoder_wr_scheduler.sv
// Channel-1 sequencer: packs decoder bytes into lines, writes them out under
// almost-full backpressure, then posts the DSM completion once all are acked.
module reed_solomon_decoder_wr_scheduler
   import reed_solomon_decoder_pkg::*;
#(
   parameter int NUM_BUFS = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [31:0]                         hc_control,
   input  t_hc_address                         hc_dsm_base,
   input  t_ccip_clAddr                        wr_base,
   input  t_ccip_clAddr                        wr_size,
   reed_solomon_decoder_wr_scheduler_if.slave  bus,
   output logic                                done,
   output logic                                overflow_err
);

   t_wrs_state         state_reg;
   t_wrs_state         state_next;
   t_ccip_clAddr       wr_offset_reg;
   t_ccip_clAddr       lines_sealed_reg;
   t_ccip_clAddr       lines_sealed_next;
   t_ccip_clAddr       wr_rsp_cnt_reg;
   t_if_ccip_c1_Tx     c1_tx_reg;
   logic               ready_reg;
   logic               ready_next;
   logic               done_reg;
   logic               overflow_reg;
   logic               accept;
   logic               seal;
   logic               pop;
   logic               full_next;
   logic               empty;
   logic               dsm_issue;
   logic               rsp_hit;
   logic               alm_full;
   logic [CL_BITS-1:0] rd_data;
   logic               unused_rx;

   assign alm_full  = bus.ccip_rx.c1TxAlmFull;
   assign accept    = bus.valid_in && ready_reg;
   assign pop       = ((state_reg == S_WRS_RUN) || (state_reg == S_WRS_DRAIN)) && !empty && !alm_full;
   assign dsm_issue = (state_reg == S_WRS_DSM) && !alm_full;
   // Responses landing while idle belong to a run that was reset away.
   assign rsp_hit   = bus.ccip_rx.c1.rspValid && (bus.ccip_rx.c1.hdr.resp_type == eRSP_WRLINE)
                      && (state_reg != S_WRS_IDLE);
   assign unused_rx = ^{bus.ccip_rx.c0TxAlmFull, bus.ccip_rx.c1.hdr.vc_used, bus.ccip_rx.c1.hdr.hit_miss,
                        bus.ccip_rx.c1.hdr.format, bus.ccip_rx.c1.hdr.cl_num, bus.ccip_rx.c1.hdr.mdata};

   reed_solomon_decoder_line_buffer #(
      .NUM_BUFS (NUM_BUFS)
   ) u_line_buffer (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (accept),
      .wr_byte   (bus.data_in),
      .pop       (pop),
      .seal      (seal),
      .full_next (full_next),
      .empty     (empty),
      .rd_data   (rd_data)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_WRS_IDLE:  if (hc_control == HC_CONTROL_START) state_next = S_WRS_RUN;
         S_WRS_RUN:   if (lines_sealed_reg == wr_size) state_next = S_WRS_DRAIN;
         S_WRS_DRAIN: if ((wr_offset_reg == wr_size) && (wr_rsp_cnt_reg == wr_size)) state_next = S_WRS_DSM;
         S_WRS_DSM:   if (!alm_full) state_next = S_WRS_DONE;
         S_WRS_DONE:  state_next = S_WRS_DONE;
         default:     state_next = S_WRS_IDLE;
      endcase
   end

   // ready is computed from next-cycle values so the flop output needs no
   // combinational qualification and never sees ccip_rx directly.
   assign lines_sealed_next = lines_sealed_reg + t_ccip_clAddr'(seal);
   assign ready_next        = (state_next == S_WRS_RUN) && !full_next && (lines_sealed_next < wr_size);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= S_WRS_IDLE;
         wr_offset_reg    <= '0;
         lines_sealed_reg <= '0;
         wr_rsp_cnt_reg   <= '0;
         ready_reg        <= 1'b0;
         done_reg         <= 1'b0;
         overflow_reg     <= 1'b0;
         c1_tx_reg        <= '0;
      end else begin
         state_reg        <= state_next;
         ready_reg        <= ready_next;
         lines_sealed_reg <= lines_sealed_next;
         if (pop) begin
            wr_offset_reg <= wr_offset_reg + t_ccip_clAddr'(1);
         end
         if (rsp_hit) begin
            wr_rsp_cnt_reg <= wr_rsp_cnt_reg + t_ccip_clAddr'(1);
         end
         if ((state_reg == S_WRS_RUN) && bus.valid_in && !ready_reg) begin
            overflow_reg <= 1'b1;
         end
         if (state_next == S_WRS_DONE) begin
            done_reg <= 1'b1;
         end

         c1_tx_reg.valid <= 1'b0;
         if (pop) begin
            c1_tx_reg.valid <= 1'b1;
            c1_tx_reg.hdr   <= wrline_hdr(wr_base + wr_offset_reg);
            c1_tx_reg.data  <= rd_data;
         end else if (dsm_issue) begin
            c1_tx_reg.valid <= 1'b1;
            c1_tx_reg.hdr   <= wrline_hdr(hc_dsm_base);
            c1_tx_reg.data  <= CL_BITS'(1);
         end
      end
   end

   assign bus.ready_out  = ready_reg;
   assign bus.ccip_c1_tx = c1_tx_reg;
   assign done           = done_reg;
   assign overflow_err   = overflow_reg;

endmodule
